image_writer: RTL and testbench
===============================

IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 40000, meaning pixels per image; a multiple of 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries; a power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin an image write; sampled only in IDLE or DONE.
REQ-006 SHALL have port in_valid  input  1  in_data holds a 4-pixel vector.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  128  four 32-bit unsigned lanes; lane i is bits [32i+31:32i]; lane 0 is the lowest pixel address.
REQ-009 SHALL have port wr_ready  input  1  image RAM accepts a write this cycle.
REQ-010 SHALL have port we  output  1  write strobe to the image RAM.
REQ-011 SHALL have port waddr  output  128  pixel address of lane 0, zero-extended.
REQ-012 SHALL have port wd  output  128  write data, four 32-bit lanes.
REQ-013 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN and DONE; reset state is IDLE.
REQ-016 SHALL move IDLE or DONE -> RUN on start=1, clearing the accept counter, the write address and the FIFO in the same edge.
REQ-017 SHALL ignore start in RUN and DRAIN.
REQ-018 SHALL drive in_ready = (state==RUN) && FIFO not full; full/empty are registered, with no combinational bypass from wr_ready.
REQ-019 SHALL push in_data into the FIFO on in_valid && in_ready, and increment the accept counter.
REQ-020 SHALL move RUN -> DRAIN on the edge that accepts beat NUM_PIXELS/4; in_ready is 0 from the next cycle.
REQ-021 SHALL drive we = (FIFO not empty) && (state is RUN or DRAIN), combinationally from registered state.
REQ-022 SHALL drive wd = saturated FIFO head and waddr = write address register whenever we=1.
REQ-023 SHALL pop on we && wr_ready and then add 4 to the write address.
REQ-024 SHALL hold we, waddr and wd stable while wr_ready=0.
REQ-025 SHALL saturate each lane to PIXEL_MAX=255: a value >255 becomes 255, otherwise it passes unchanged (unsigned compare).
REQ-026 SHALL leave the FIFO count unchanged on a simultaneous push and pop; a push when full is impossible by REQ-018.
REQ-027 SHALL move DRAIN -> DONE on the edge that pops the last entry; done is high from the next cycle until start.
REQ-028 SHALL give a latency of 1 cycle from acceptance to first we when the FIFO is empty and wr_ready=1.
REQ-029 SHALL sustain throughput of 1 beat/cycle when in_valid=1 and wr_ready=1.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-image: state=IDLE, FIFO empty, counters=0, in_ready=0, we=0, waddr=0, wd=0, busy=0, done=0.
REQ-031 SHALL, after rst returns to 1, do nothing until start.

Structure
REQ-032 SHALL take LANE_W=32, LANES=4, PIXEL_MAX=255 and the writer state enum from shared package image_pkg.
REQ-033 SHALL place the FIFO in sub-module vec_fifo (width 128, depth FIFO_DEPTH, push, pop, full, empty, head); the FSM, counters and saturation stay in image_writer.

Verification
REQ-034 SHALL cover: start, then one beat {118,114,108,106} (lane3..lane0), wr_ready=1 -> next cycle we=1, waddr=0, wd lanes {118,114,108,106}.
REQ-035 SHALL cover: beat lanes {1000,256,255,0} -> wd lanes {255,255,255,0}.
REQ-036 SHALL cover: wr_ready=0 while 5 beats are offered -> 4 accepted, in_ready=0, we held with waddr=0; wr_ready=1 -> writes at waddr 0,4,8,12, then the 5th beat is accepted.
REQ-037 SHALL cover: NUM_PIXELS=16, 4 back-to-back beats -> writes at 0,4,8,12, in_ready=0 after the 4th accept, done=1 one cycle after the last write, busy=0.
REQ-038 SHALL cover: rst=0 mid-image with 2 FIFO entries -> all outputs 0 asynchronously; a new start writes from waddr=0 with no stale data.
REQ-039 SHALL cover: start pulse during RUN -> address and counter sequence undisturbed.

Source files
------------

// File: rtl/image_pkg.sv
// Shared definitions for the image writer: lane geometry, pixel ceiling,
// writer state encoding and the per-lane saturation helper.
package image_pkg;

    localparam int LANE_W = 32;
    localparam int LANES  = 4;
    localparam int VEC_W  = LANE_W * LANES;

    localparam logic [LANE_W-1:0] PIXEL_MAX = 32'd255;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } writer_state_t;

    // Clamp every unsigned lane to PIXEL_MAX; lanes at or below it pass through.
    function automatic logic [VEC_W-1:0] saturate_vec(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0]  r;
        logic [LANE_W-1:0] lane;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = v[i*LANE_W +: LANE_W];
            r[i*LANE_W +: LANE_W] = (lane > PIXEL_MAX) ? PIXEL_MAX : lane;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// Small synchronous FIFO of pixel vectors with registered full/empty flags
// and a synchronous clear used when a new image starts.
module vec_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Flags are computed from the next count so they are ready as plain registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr] <= din;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/image_writer.sv
// Streams NUM_PIXELS/4 four-pixel beats through a small FIFO into the image
// RAM, saturating each lane to PIXEL_MAX on the way out.
module image_writer
    import image_pkg::*;
#(
    parameter int NUM_PIXELS = 40000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_data,
    input  logic             wr_ready,
    output logic             we,
    output logic [VEC_W-1:0] waddr,
    output logic [VEC_W-1:0] wd,
    output logic             busy,
    output logic             done
);

    localparam int BEATS   = NUM_PIXELS / LANES;
    localparam int CNT_W   = $clog2(BEATS + 1);
    localparam int ADDR_W  = $clog2(NUM_PIXELS + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    writer_state_t     state;
    logic [CNT_W-1:0]  accept_cnt;
    logic [ADDR_W-1:0] waddr_r;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [VEC_W-1:0]  fifo_head;
    logic              fifo_clear;
    logic              accept;
    logic              pop;

    assign fifo_clear = start && (state == IDLE || state == DONE);
    assign in_ready   = (state == RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign we         = !fifo_empty && (state == RUN || state == DRAIN);
    assign pop        = we && wr_ready;

    assign wd    = we ? saturate_vec(fifo_head) : '0;
    assign waddr = {{(VEC_W-ADDR_W){1'b0}}, waddr_r};
    assign busy  = (state == RUN) || (state == DRAIN);
    assign done  = (state == DONE);

    vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (accept),
        .pop   (pop),
        .din   (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // DRAIN only ends on the pop that empties the FIFO, so done follows the last write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            accept_cnt <= '0;
            waddr_r    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        accept_cnt <= '0;
                        waddr_r    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        accept_cnt <= accept_cnt + CNT_W'(1);
                        if (accept_cnt == CNT_W'(BEATS - 1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && fifo_count == FCNT_W'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
            if (pop) waddr_r <= waddr_r + ADDR_W'(LANES);
        end
    end

endmodule

// File: tb/tb_image_writer.sv
// Directed bench for image_writer: a 32-pixel instance for most scenarios and
// a 16-pixel instance, sharing the same inputs, for the full-image case.
module tb_image_writer;

    logic         clk;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [127:0] in_data;
    logic         wr_ready;

    logic         in_ready, we, busy, done;
    logic [127:0] waddr, wd;
    logic         s_in_ready, s_we, s_busy, s_done;
    logic [127:0] s_waddr, s_wd;

    int compared   = 0;
    int mismatched = 0;

    image_writer #(.NUM_PIXELS(32), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .wr_ready (wr_ready),
        .we       (we),
        .waddr    (waddr),
        .wd       (wd),
        .busy     (busy),
        .done     (done)
    );

    image_writer #(.NUM_PIXELS(16), .FIFO_DEPTH(4)) dut_small (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (s_in_ready),
        .in_data  (in_data),
        .wr_ready (wr_ready),
        .we       (s_we),
        .waddr    (s_waddr),
        .wd       (s_wd),
        .busy     (s_busy),
        .done     (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] vec(input int a3, input int a2, input int a1, input int a0);
        return {a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
    endfunction

    function automatic logic [127:0] beat(input int k);
        return vec(10*k + 3, 10*k + 2, 10*k + 1, 10*k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] d, input logic wr);
        in_valid = v;
        in_data  = d;
        wr_ready = wr;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #12;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_we", we, 0);
        checkOutput("rst_waddr", waddr, 0);
        checkOutput("rst_wd", wd, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_in_ready", in_ready, 0);

        $display("[TB] single beat, first-write latency");
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("run_busy", busy, 1);
        checkOutput("run_in_ready", in_ready, 1);
        checkOutput("run_we_empty", we, 0);
        applyStimulus(1'b1, vec(118, 114, 108, 106), 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("b1_we", we, 1);
        checkOutput("b1_waddr", waddr, 0);
        checkOutput("b1_wd", wd, vec(118, 114, 108, 106));
        tick();
        checkOutput("b1_we_after", we, 0);

        $display("[TB] saturation");
        applyStimulus(1'b1, vec(1000, 256, 255, 0), 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("sat_we", we, 1);
        checkOutput("sat_waddr", waddr, 4);
        checkOutput("sat_wd", wd, vec(255, 255, 255, 0));
        tick();
        checkOutput("sat_we_after", we, 0);

        $display("[TB] backpressure with full fifo");
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, beat(k), 1'b0);
            checkOutput($sformatf("bp_ready_%0d", k), in_ready, 1);
            tick();
        end
        applyStimulus(1'b1, beat(4), 1'b0);
        checkOutput("bp_full_ready", in_ready, 0);
        checkOutput("bp_full_we", we, 1);
        checkOutput("bp_full_waddr", waddr, 0);
        tick();
        checkOutput("bp_hold_ready", in_ready, 0);
        checkOutput("bp_hold_we", we, 1);
        checkOutput("bp_hold_waddr", waddr, 0);
        checkOutput("bp_hold_wd", wd, beat(0));
        wr_ready = 1'b1;
        tick();
        checkOutput("bp_w1_ready", in_ready, 1);
        checkOutput("bp_w1_waddr", waddr, 4);
        checkOutput("bp_w1_wd", wd, beat(1));
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("bp_w2_waddr", waddr, 8);
        checkOutput("bp_w2_wd", wd, beat(2));
        tick();
        checkOutput("bp_w3_waddr", waddr, 12);
        checkOutput("bp_w3_wd", wd, beat(3));
        tick();
        checkOutput("bp_w4_waddr", waddr, 16);
        checkOutput("bp_w4_wd", wd, beat(4));
        tick();
        checkOutput("bp_empty_we", we, 0);

        $display("[TB] start ignored while running");
        start = 1'b1;
        applyStimulus(1'b1, beat(5), 1'b1);
        tick();
        start = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("st_busy", busy, 1);
        checkOutput("st_we", we, 1);
        checkOutput("st_waddr", waddr, 20);
        checkOutput("st_wd", wd, beat(5));
        tick();
        checkOutput("st_we_after", we, 0);

        $display("[TB] full 16-pixel image");
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, beat(k), 1'b1);
            tick();
            checkOutput($sformatf("img_we_%0d", k), s_we, 1);
            checkOutput($sformatf("img_waddr_%0d", k), s_waddr, 128'(4*k));
        end
        checkOutput("img_ready_last", s_in_ready, 0);
        checkOutput("img_busy_drain", s_busy, 1);
        applyStimulus(1'b0, '0, 1'b1);
        tick();
        checkOutput("img_done", s_done, 1);
        checkOutput("img_busy_done", s_busy, 0);
        checkOutput("img_we_done", s_we, 0);
        tick();
        checkOutput("img_done_hold", s_done, 1);

        $display("[TB] reset mid-image");
        applyStimulus(1'b1, beat(6), 1'b0);
        tick();
        applyStimulus(1'b1, beat(7), 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("mid_we", we, 1);
        checkOutput("mid_waddr", waddr, 16);
        checkOutput("mid_wd", wd, beat(6));
        rst = 1'b0;
        #1;
        checkOutput("arst_in_ready", in_ready, 0);
        checkOutput("arst_we", we, 0);
        checkOutput("arst_waddr", waddr, 0);
        checkOutput("arst_wd", wd, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        #1;
        rst = 1'b1;
        tick();
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_we", we, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_we", we, 0);
        checkOutput("restart_ready", in_ready, 1);
        applyStimulus(1'b1, vec(40, 30, 20, 10), 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("restart_w_we", we, 1);
        checkOutput("restart_w_waddr", waddr, 0);
        checkOutput("restart_w_wd", wd, vec(40, 30, 20, 10));
        tick();
        checkOutput("restart_we_after", we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
